// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte producers,
// with packet lock, start/done handshake, optional inter-frame gap and tx_done watchdog.
module uart_tx_arbiter #(
    parameter int NREQ       = 2,
    parameter int GAP_CYCLES = 0,
    parameter int TIMEOUT    = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   grant,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_done,
    output logic              busy,
    output logic              timeout_err,
    input  logic              err_clr
);

    localparam int PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW       = $clog2(TIMEOUT + 1);
    localparam int GW       = $clog2(GAP_CYCLES + 2);
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic              lock_q, lock_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [GW-1:0]     gap_q, gap_d;

    logic              win_found;
    logic [PW-1:0]     winner;
    logic [NREQ-1:0]   win_onehot;
    logic              err_set;

    // While locked only the current owner may win; otherwise search from ptr+1 upward.
    always_comb begin
        win_found = 1'b0;
        winner    = ptr_q;
        if (lock_q) begin
            win_found = req_valid[ptr_q];
        end else begin
            for (int k = 1; k <= NREQ; k++) begin
                if (!win_found && req_valid[(int'(ptr_q) + k) % NREQ]) begin
                    win_found = 1'b1;
                    winner    = PW'((int'(ptr_q) + k) % NREQ);
                end
            end
        end
        win_onehot = NREQ'(1) << winner;
    end

    assign req_ready = (state_q == S_IDLE && win_found) ? win_onehot : '0;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_d     = lock_q;
        grant_d    = grant_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        timer_d    = timer_q;
        gap_d      = gap_q;
        err_set    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    tx_data_d  = req_data[{winner, 3'b000} +: 8];
                    grant_d    = win_onehot;
                    ptr_d      = winner;
                    lock_d     = ~req_last[winner];
                    tx_start_d = 1'b1;
                    state_d    = S_START;
                end
            end
            S_START: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                // A done pulse on the final watchdog cycle still counts as success.
                if (tx_done) begin
                    grant_d = lock_q ? grant_q : '0;
                    gap_d   = '0;
                    state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    err_set = 1'b1;
                    lock_d  = 1'b0;
                    grant_d = '0;
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GW'(GAP_LAST)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        err_d  = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= PW'(NREQ - 1);
            lock_q     <= 1'b0;
            grant_q    <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            timer_q    <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            grant_q    <= grant_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            timer_q    <= timer_d;
            gap_q      <= gap_d;
        end
    end

    assign grant       = grant_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign busy        = busy_q;
    assign timeout_err = err_q;

endmodule
